// File: rtl/gerenciador_alarme_if.sv
// Operator-facing alarm bus: raw/operator inputs toward the manager, drive outputs back.
// master = stimulus side (control room / bench), slave = the alarm manager.
interface gerenciador_alarme_if #(
  parameter int CNT_W = 8
);
  logic             alarme_in;
  logic             reconhecer;
  logic             libera_evac;
  logic             sirene;
  logic             luz_alerta;
  logic             evacuacao;
  logic [2:0]       estado;
  logic [CNT_W-1:0] num_eventos;

  modport master (
    output alarme_in, reconhecer, libera_evac,
    input  sirene, luz_alerta, evacuacao, estado, num_eventos
  );

  modport slave (
    input  alarme_in, reconhecer, libera_evac,
    output sirene, luz_alerta, evacuacao, estado, num_eventos
  );
endinterface

// File: rtl/gerenciador_alarme.sv
// Alarm manager: debounces the control-room alarm flag, latches it, drives siren/light,
// handles operator acknowledge and escalates to evacuation; counts confirmed events.
module gerenciador_alarme #(
  parameter int CONFIRM_CYC = 4,
  parameter int ESCALA_CYC  = 16,
  parameter int BLINK_PER   = 4,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gerenciador_alarme_if.slave  alm
);
  localparam logic [2:0] S_NORMAL      = 3'd0;
  localparam logic [2:0] S_CONFIRMA    = 3'd1;
  localparam logic [2:0] S_ATIVO       = 3'd2;
  localparam logic [2:0] S_RECONHECIDO = 3'd3;
  localparam logic [2:0] S_EVACUACAO   = 3'd4;

  localparam logic [7:0] CONF_LAST  = 8'(CONFIRM_CYC - 1);
  localparam logic [7:0] ESC_LAST   = 8'(ESCALA_CYC - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_PER - 1);

  logic [2:0]       state_q, state_d;
  logic [7:0]       timer_q, timer_d;
  logic [7:0]       blink_q, blink_d;
  logic             luz_q, luz_d;
  logic             alarme_r_q;
  logic [CNT_W-1:0] num_q, num_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_NORMAL;
      timer_q    <= '0;
      blink_q    <= '0;
      luz_q      <= 1'b0;
      alarme_r_q <= 1'b0;
      num_q      <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      blink_q    <= blink_d;
      luz_q      <= luz_d;
      alarme_r_q <= alm.alarme_in;
      num_q      <= num_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    blink_d = blink_q;
    luz_d   = luz_q;
    num_d   = num_q;
    case (state_q)
      S_NORMAL: begin
        if (alarme_r_q) begin
          state_d = S_CONFIRMA;
          timer_d = 8'd1;
        end
      end
      S_CONFIRMA: begin
        if (!alarme_r_q) begin
          state_d = S_NORMAL;
          timer_d = '0;
        end else if (timer_q == CONF_LAST) begin
          state_d = S_ATIVO;
          timer_d = '0;
          num_d   = (num_q == {CNT_W{1'b1}}) ? num_q : num_q + 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_ATIVO: begin
        // escalation wins over an acknowledge arriving on the same edge
        if (timer_q == ESC_LAST) begin
          state_d = S_EVACUACAO;
          timer_d = '0;
        end else if (alm.reconhecer) begin
          state_d = S_RECONHECIDO;
          timer_d = '0;
          luz_d   = 1'b1;
          blink_d = '0;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_RECONHECIDO: begin
        if (blink_q == BLINK_LAST) begin
          luz_d   = ~luz_q;
          blink_d = '0;
        end else begin
          blink_d = blink_q + 8'd1;
        end
        if (!alarme_r_q) begin
          state_d = S_NORMAL;
          timer_d = '0;
        end else if (timer_q == ESC_LAST) begin
          state_d = S_EVACUACAO;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_EVACUACAO: begin
        if (alm.libera_evac && !alarme_r_q) begin
          state_d = S_NORMAL;
          timer_d = '0;
        end
      end
      default: begin
        state_d = S_NORMAL;
        timer_d = '0;
      end
    endcase
  end

  assign alm.estado      = state_q;
  assign alm.sirene      = (state_q == S_ATIVO) || (state_q == S_EVACUACAO);
  assign alm.luz_alerta  = (state_q == S_ATIVO) || (state_q == S_EVACUACAO) ||
                           ((state_q == S_RECONHECIDO) && luz_q);
  assign alm.evacuacao   = (state_q == S_EVACUACAO);
  assign alm.num_eventos = num_q;
endmodule

// File: tb/tb_gerenciador_alarme.sv
// Bench for gerenciador_alarme: directed vector table, hand sequences for escalation,
// reset and counter saturation, then random stimulus against a behavioural model.
module tb_gerenciador_alarme;
  localparam int CONFIRM = 4;
  localparam int ESCALA  = 16;
  localparam int BLINK   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  gerenciador_alarme_if #(.CNT_W(8)) if1 ();
  gerenciador_alarme_if #(.CNT_W(2)) if2 ();

  gerenciador_alarme #(.CONFIRM_CYC(CONFIRM), .ESCALA_CYC(ESCALA), .BLINK_PER(BLINK), .CNT_W(8))
    dut (.clk(clk), .rst_n(rst_n), .alm(if1));
  gerenciador_alarme #(.CONFIRM_CYC(CONFIRM), .ESCALA_CYC(ESCALA), .BLINK_PER(BLINK), .CNT_W(2))
    dut2 (.clk(clk), .rst_n(rst_n), .alm(if2));

  typedef struct {
    logic a, r, l;
    int   est;
    logic s, lz, ev;
    int   num;
  } vec_t;
  vec_t tbl[26];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic a, input logic r, input logic l);
    if1.alarme_in = a; if1.reconhecer = r; if1.libera_evac = l;
  endtask

  task automatic chk_all(input string nm, input int est, input logic s, input logic lz,
                         input logic ev, input int num);
    chk({nm, ".estado"}, 32'(if1.estado), 32'(est));
    chk({nm, ".sirene"}, 32'(if1.sirene), 32'(s));
    chk({nm, ".luz"},    32'(if1.luz_alerta), 32'(lz));
    chk({nm, ".evac"},   32'(if1.evacuacao), 32'(ev));
    chk({nm, ".num"},    32'(if1.num_eventos), 32'(num));
  endtask

  // Behavioural model: idle phase tracks the run length of high samples,
  // alarm phases track age since entry; the light blinks by age/BLINK parity.
  localparam int P_IDLE = 0, P_ATIVO = 2, P_RECON = 3, P_EVAC = 4;
  int   m_phase, m_run, m_age, m_num;
  logic m_ar;

  task automatic model_edge(input logic a, input logic rec, input logic lib);
    case (m_phase)
      P_IDLE: begin
        if (m_ar) begin
          m_run++;
          if (m_run == CONFIRM) begin
            m_phase = P_ATIVO; m_age = 0; m_run = 0;
            if (m_num < 255) m_num++;
          end
        end else m_run = 0;
      end
      P_ATIVO: begin
        if (m_age + 1 == ESCALA) m_phase = P_EVAC;
        else if (rec) begin m_phase = P_RECON; m_age = 0; end
        else m_age++;
      end
      P_RECON: begin
        if (!m_ar) begin m_phase = P_IDLE; m_run = 0; end
        else if (m_age + 1 == ESCALA) m_phase = P_EVAC;
        else m_age++;
      end
      default: begin
        if (lib && !m_ar) begin m_phase = P_IDLE; m_run = 0; end
      end
    endcase
    m_ar = a;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
    $fatal(1);
  end

  initial begin
    logic a, rec, lib;
    int   e_est;
    logic e_s, e_lz, e_ev;

    tbl[0]  = '{1,0,0, 0,0,0,0, 0};
    tbl[1]  = '{1,0,0, 1,0,0,0, 0};
    tbl[2]  = '{1,0,0, 1,0,0,0, 0};
    tbl[3]  = '{0,0,0, 1,0,0,0, 0};
    tbl[4]  = '{0,0,0, 0,0,0,0, 0};
    tbl[5]  = '{0,0,0, 0,0,0,0, 0};
    tbl[6]  = '{1,0,0, 0,0,0,0, 0};
    tbl[7]  = '{1,0,0, 1,0,0,0, 0};
    tbl[8]  = '{1,0,0, 1,0,0,0, 0};
    tbl[9]  = '{1,0,0, 1,0,0,0, 0};
    tbl[10] = '{1,0,0, 2,1,1,0, 1};
    tbl[11] = '{1,0,0, 2,1,1,0, 1};
    tbl[12] = '{0,0,0, 2,1,1,0, 1};
    tbl[13] = '{0,0,0, 2,1,1,0, 1};
    tbl[14] = '{1,0,0, 2,1,1,0, 1};
    tbl[15] = '{1,1,0, 3,0,1,0, 1};
    tbl[16] = '{1,0,0, 3,0,1,0, 1};
    tbl[17] = '{1,0,0, 3,0,1,0, 1};
    tbl[18] = '{1,0,0, 3,0,1,0, 1};
    tbl[19] = '{1,0,0, 3,0,0,0, 1};
    tbl[20] = '{1,0,0, 3,0,0,0, 1};
    tbl[21] = '{1,0,0, 3,0,0,0, 1};
    tbl[22] = '{1,0,0, 3,0,0,0, 1};
    tbl[23] = '{1,0,0, 3,0,1,0, 1};
    tbl[24] = '{0,0,0, 3,0,1,0, 1};
    tbl[25] = '{0,0,0, 0,0,0,0, 1};

    drive1(0, 0, 0);
    if2.alarme_in = 0; if2.reconhecer = 0; if2.libera_evac = 0;

    // reset state
    step(); step();
    chk_all("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    chk_all("post_reset", 0, 0, 0, 0, 0);
    $display("reset: estado=%0d num=%0d", if1.estado, if1.num_eventos);

    // glitch, confirm/latch, acknowledge/blink/clear
    for (int i = 0; i < 26; i++) begin
      drive1(tbl[i].a, tbl[i].r, tbl[i].l);
      step();
      $display("vec %0d: a=%0b r=%0b -> estado=%0d sirene=%0b luz=%0b evac=%0b num=%0d",
               i, tbl[i].a, tbl[i].r, if1.estado, if1.sirene, if1.luz_alerta,
               if1.evacuacao, if1.num_eventos);
      chk_all($sformatf("vec%0d", i), tbl[i].est, tbl[i].s, tbl[i].lz, tbl[i].ev, tbl[i].num);
    end
    drive1(0, 0, 0);

    // escalation without acknowledge
    drive1(1, 0, 0);
    step();
    for (int i = 0; i < CONFIRM; i++) step();
    chk_all("esc_entry", 2, 1, 1, 0, 2);
    for (int i = 0; i < ESCALA - 1; i++) step();
    chk_all("esc_pre", 2, 1, 1, 0, 2);
    step();
    chk_all("esc_evac", 4, 1, 1, 1, 2);
    $display("escalation: estado=%0d evac=%0b", if1.estado, if1.evacuacao);
    drive1(1, 0, 1);
    step(); step(); step();
    chk_all("evac_hold", 4, 1, 1, 1, 2);
    drive1(0, 0, 0);
    step(); step();
    chk_all("evac_wait", 4, 1, 1, 1, 2);
    drive1(0, 0, 1);
    step();
    chk_all("evac_clear", 0, 0, 0, 0, 2);
    $display("evac release: estado=%0d", if1.estado);
    drive1(0, 0, 0);
    step();

    // acknowledge on the escalation edge loses to escalation
    drive1(1, 0, 0);
    step();
    for (int i = 0; i < CONFIRM; i++) step();
    chk_all("simul_entry", 2, 1, 1, 0, 3);
    for (int i = 0; i < ESCALA - 1; i++) step();
    drive1(1, 1, 0);
    step();
    chk_all("simul_evac", 4, 1, 1, 1, 3);
    $display("simultaneous: estado=%0d", if1.estado);
    drive1(0, 0, 0);

    // asynchronous reset mid-evacuation
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0);
    $display("async reset: estado=%0d num=%0d", if1.estado, if1.num_eventos);
    step();
    rst_n = 1'b1;
    step();
    chk_all("after_rst", 0, 0, 0, 0, 0);

    // saturating counter on the 2-bit instance
    for (int k = 1; k <= 5; k++) begin
      if2.alarme_in = 1;
      for (int i = 0; i < CONFIRM + 1; i++) step();
      chk($sformatf("sat%0d.estado", k), 32'(if2.estado), 32'd2);
      if2.reconhecer = 1;
      step();
      if2.reconhecer = 0;
      if2.alarme_in = 0;
      step(); step();
      chk($sformatf("sat%0d.idle", k), 32'(if2.estado), 32'd0);
      chk($sformatf("sat%0d.num", k), 32'(if2.num_eventos), 32'((k > 3) ? 3 : k));
      $display("saturation event %0d: num=%0d", k, if2.num_eventos);
    end

    // random stimulus against the model
    m_phase = P_IDLE; m_run = 0; m_age = 0; m_num = 0; m_ar = 0;
    a = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) a = ~a;
      rec = ($urandom_range(0, 11) == 0);
      lib = ($urandom_range(0, 5) == 0);
      drive1(a, rec, lib);
      step();
      model_edge(a, rec, lib);
      e_est = (m_phase == P_IDLE) ? ((m_run > 0) ? 1 : 0) : m_phase;
      e_s   = (m_phase == P_ATIVO) || (m_phase == P_EVAC);
      e_ev  = (m_phase == P_EVAC);
      e_lz  = e_s || ((m_phase == P_RECON) && (((m_age / BLINK) % 2) == 0));
      $display("rnd %0d: a=%0b r=%0b l=%0b estado=%0d/%0d num=%0d/%0d",
               c, a, rec, lib, if1.estado, e_est, if1.num_eventos, m_num);
      chk_all($sformatf("rnd%0d", c), e_est, e_s, e_lz, e_ev, m_num);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
